// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler: records minute-tick matches as pending flags and fires them one at a time into the buzzer.
// Build option ALARM_SCHED_ROUND_ROBIN_EN selects round-robin slot selection; without it the lowest pending index wins.
module alarm_scheduler #(
    parameter int NUM_ALARMS    = 4,
    parameter int IDX_W         = 2,
    parameter int START_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            cur_hour,
    input  logic [5:0]            cur_min,
    input  logic                  min_tick,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [4:0]            wr_hour,
    input  logic [5:0]            wr_min,
    input  logic                  wr_enable,
    input  logic                  stop_all,
    input  logic                  buzz_busy,
    output logic                  trigger,
    output logic [IDX_W-1:0]      active_idx,
    output logic [NUM_ALARMS-1:0] pending,
    output logic                  missed,
    output logic [1:0]            state_dbg
);

    // Handshake: trigger is a one-cycle request with no ready; the buzzer acknowledges by raising
    // buzz_busy within START_TIMEOUT cycles and releases the scheduler by dropping it when idle again.
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_FIRE       = 2'd1,
        S_WAIT_START = 2'd2,
        S_WAIT_DONE  = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [4:0]            slot_hour [NUM_ALARMS];
    logic [5:0]            slot_min  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] slot_en;
    logic [NUM_ALARMS-1:0] match, pending_n;
    logic [CNT_W-1:0]      wait_cnt, wait_cnt_n;
    logic                  fire, trigger_n, missed_n;
    logic [IDX_W-1:0]      sel;

    assign state_dbg = state;

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_ALARMS; i++)
            match[i] = slot_en[i] && (slot_hour[i] == cur_hour) && (slot_min[i] == cur_min);
    end

`ifdef ALARM_SCHED_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;
    logic             found;

    // Search starts one past the last fired slot and wraps.
    always_comb begin : rr_select
        int cand;
        sel   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 1; i <= NUM_ALARMS; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_ALARMS;
            if (!found && pending[cand]) begin
                sel   = IDX_W'(cand);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= IDX_W'(NUM_ALARMS - 1);
        else if (state == S_FIRE)
            rr_ptr <= active_idx;
    end
`else
    always_comb begin
        sel = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--)
            if (pending[i]) sel = IDX_W'(i);
    end
`endif

    // Order matters: disable-write clear, then match OR, then fire clear, then stop_all wins.
    always_comb begin
        pending_n = pending;
        if (wr_en && !wr_enable) pending_n[wr_idx] = 1'b0;
        if (min_tick)            pending_n = pending_n | match;
        if (fire)                pending_n[sel] = 1'b0;
        if (stop_all)            pending_n = '0;
    end

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        trigger_n  = 1'b0;
        missed_n   = 1'b0;
        fire       = 1'b0;
        case (state)
            S_IDLE: begin
                if ((|pending) && !buzz_busy) begin
                    fire      = 1'b1;
                    trigger_n = 1'b1;
                    state_n   = S_FIRE;
                end
            end
            S_FIRE: begin
                wait_cnt_n = '0;
                state_n    = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (buzz_busy) begin
                    state_n = S_WAIT_DONE;
                end else if (wait_cnt == CNT_W'(START_TIMEOUT - 1)) begin
                    missed_n = 1'b1;
                    state_n  = S_IDLE;
                end else begin
                    wait_cnt_n = wait_cnt + CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!buzz_busy) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            trigger    <= 1'b0;
            missed     <= 1'b0;
            active_idx <= '0;
            pending    <= '0;
            slot_en    <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_hour[i] <= '0;
                slot_min[i]  <= '0;
            end
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            trigger  <= trigger_n;
            missed   <= missed_n;
            pending  <= pending_n;
            if (fire) active_idx <= sel;
            if (wr_en) begin
                slot_hour[wr_idx] <= wr_hour;
                slot_min[wr_idx]  <= wr_min;
                slot_en[wr_idx]   <= wr_enable;
            end
        end
    end

endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Multi-slot alarm scheduler that sits between the time-of-day counter and the alarm buzzer. It holds `NUM_ALARMS` programmable alarm slots and compares them against the current time on every minute rollover. It queues the alarms that match and sequences them one at a time into the buzzer's `Trigger` input. It will not start a new alarm while the buzzer is still ringing, snoozing or counting down.

## Interface
- `NUM_ALARMS`, 4: number of alarm slots (2..8).
- `IDX_W`, 2: index width, equal to clog2(`NUM_ALARMS`).
- `START_TIMEOUT`, 8: cycles to wait for the buzzer to go busy after a trigger.
- `clk  in  1`: system clock; all logic is on the rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `cur_hour  in  5`: current hour, 0..23.
- `cur_min  in  6`: current minute, 0..59.
- `min_tick  in  1`: one-cycle pulse; `cur_hour`/`cur_min` hold the new minute in this cycle.
- `wr_en  in  1`: slot write strobe.
- `wr_idx  in  IDX_W`: slot to write.
- `wr_hour  in  5`, `wr_min  in  6`, `wr_enable  in  1`: new contents for the slot.
- `stop_all  in  1`: clears all pending alarms.
- `buzz_busy  in  1`: high while the buzzer is in any non-idle state (ringing or snoozing).
- `trigger  out  1`: one-cycle pulse to the buzzer `Trigger` input.
- `active_idx  out  IDX_W`: index of the most recently fired slot.
- `pending  out  NUM_ALARMS`: per-slot pending flags.
- `missed  out  1`: one-cycle pulse when the buzzer did not respond to a trigger.

## Operation
- **Slots.** Each slot holds hour, minute and enable.
  - A write takes effect at the next edge.
  - Writing a slot with `wr_enable`=0 also clears that slot's pending bit.
- **Match.** In a `min_tick` cycle, every enabled slot whose hour and minute equal `cur_hour`/`cur_min` gets its pending bit set (OR into existing bits).
  - The compare uses slot contents from before any same-cycle write.
  - A slot that is already pending stays pending; matches never count twice.
- **Precedence.** `stop_all` clears all pending bits and overrides any same-cycle match. It does not abort a trigger already issued.
- **FSM states:**
  - **IDLE:** if `pending` is non-zero and `buzz_busy`=0, select a slot, clear its pending bit and go to FIRE.
  - **FIRE:** `trigger`=1 for exactly this cycle, `active_idx` is loaded with the selected slot, go to WAIT_START.
  - **WAIT_START:** if `buzz_busy`=1, go to WAIT_DONE. If `START_TIMEOUT` cycles pass without it, pulse `missed` and go to IDLE. The alarm is not re-pended.
  - **WAIT_DONE:** stay while `buzz_busy`=1; go to IDLE on `buzz_busy`=0.
- **Selection:** lowest-index pending slot (see Configuration).
- **Mid-operation reset:** returns everything to reset values within one edge; an in-flight trigger is dropped.

## Timing
- **Reset values:**
  - `trigger`=0, `missed`=0, `active_idx`=0, `pending`=0.
  - FSM in IDLE; all slots 0:00 and disabled.
  - Round-robin pointer = `NUM_ALARMS`-1.
- **Latency:** with `min_tick` in cycle t and the buzzer idle:
  - `pending` is visible in cycle t+1;
  - `trigger` is high in cycle t+2;
  - that slot's pending bit is clear in cycle t+2.
- **Registers:** all outputs are registered; there are no combinational input-to-output paths.
- **Busy gating:**
  - A new trigger needs `buzz_busy`=0 in IDLE.
  - Minimum spacing between triggers is 3 cycles plus the buzzer busy time.
- **Timeout:** with `trigger` in cycle f and `buzz_busy` staying low, `missed` is high in cycle f+`START_TIMEOUT`+1.
- **Same-cycle events:** `min_tick` and a WAIT_DONE exit in the same cycle are independent. The match is recorded and fires from IDLE afterwards.

## Configuration
- **`ALARM_SCHED_ROUND_ROBIN_EN` defined:** round-robin selection. The search starts at the index after the last fired slot and wraps at `NUM_ALARMS`-1 → 0. The pointer updates in FIRE.
- **`ALARM_SCHED_ROUND_ROBIN_EN` not defined:** fixed priority, lowest index wins, and no pointer register exists.
- All other behaviour is identical in both builds.

## Test plan
- **Single alarm:** write slot 1 = 07:30, enabled; pulse `min_tick` with 07:30 → `pending`=0010 next cycle, `trigger` 2 cycles after the tick, `active_idx`=1, `pending`=0000.
- **Busy hold:** slots 0 and 2 at 06:00; tick at 06:00; bench drives `buzz_busy` high 1 cycle after the first trigger, for 100 cycles →
  - first trigger fires `active_idx`=0, second stays pending;
  - second trigger (`active_idx`=2) comes 2 cycles after `buzz_busy` falls.
- **Round-robin build:** slots 0 and 1 at 05:00; fire slot 1 once, then tick again at 05:00 with both matching → first trigger goes to slot 0 with the macro off, to slot 0 after slot 1 with the macro on (pointer at 1 → next is 0). Repeat with the pointer at 0 → slot 1 is served first with the macro on.
- **Precedence:**
  - `stop_all` in the same cycle as a matching `min_tick` → `pending` stays 0 and no trigger.
  - A write disabling slot 3 in the tick cycle → the match still registers.
  - A disable write one cycle later → pending bit 3 clears and no trigger.
- **Timeout:** hold `buzz_busy`=0 after a trigger → `missed` pulses once `START_TIMEOUT`+1 cycles after `trigger`, FSM returns to IDLE, nothing re-pended.
- **Reset mid-WAIT_DONE:** assert `reset` with `pending`=0101 → next cycle all outputs at reset values; no trigger after release.
